// File: rtl/sbox_gen_responder_if.sv
// Byte-lookup bus between the subbytes sequencer (master) and the S-box responder (slave).
// Carries the request byte with its direction select, the registered result and the table-ready flag.
interface sbox_gen_responder_if;
  logic [7:0] data_i;
  logic       decrypt_i;
  logic [7:0] data_o;
  logic       init_done_o;

  modport master (
    output data_i,
    output decrypt_i,
    input  data_o,
    input  init_done_o
  );

  modport slave (
    input  data_i,
    input  decrypt_i,
    output data_o,
    output init_done_o
  );
endinterface

// File: rtl/sbox_gen_responder.sv
// Forward/inverse AES S-box responder whose tables are built in place by a GF(2^8) walk after reset.
// Lookup latency 1 clock, one per cycle, no backpressure; requests before init_done_o are dropped.
module sbox_gen_responder #(
  parameter logic [7:0] AFFINE_C = 8'h63
) (
  input  logic                 clk,
  input  logic                 reset,
  sbox_gen_responder_if.slave  sbox
);

  typedef enum logic [1:0] {GEN, ZERO, READY} state_e;

  state_e     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic [7:0] q_q, q_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;

  logic [7:0] fwd_mem [256];
  logic [7:0] inv_mem [256];

  logic       fwd_we, inv_we;
  logic [7:0] fwd_waddr, fwd_wdat;
  logic [7:0] inv_waddr, inv_wdat;

  logic [7:0] p_nxt, q_nxt, x_nxt;
  logic [7:0] q_t1, q_t2, q_t3;

  // p walks the powers of 3; q tracks the matching power of 3^-1, i.e. q = p^-1.
  always_comb begin
    p_nxt = p_q ^ {p_q[6:0], 1'b0} ^ (p_q[7] ? 8'h1B : 8'h00);
    q_t1  = q_q ^ {q_q[6:0], 1'b0};
    q_t2  = q_t1 ^ {q_t1[5:0], 2'b00};
    q_t3  = q_t2 ^ {q_t2[3:0], 4'h0};
    q_nxt = q_t3 ^ (q_t3[7] ? 8'h09 : 8'h00);
    x_nxt = q_nxt ^ {q_nxt[6:0], q_nxt[7]} ^ {q_nxt[5:0], q_nxt[7:6]}
          ^ {q_nxt[4:0], q_nxt[7:5]} ^ {q_nxt[3:0], q_nxt[7:4]} ^ AFFINE_C;
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    data_d    = 8'h00;
    done_d    = done_q;
    fwd_we    = 1'b0;
    inv_we    = 1'b0;
    fwd_waddr = 8'h00;
    fwd_wdat  = 8'h00;
    inv_waddr = 8'h00;
    inv_wdat  = 8'h00;
    case (state_q)
      GEN: begin
        p_d       = p_nxt;
        q_d       = q_nxt;
        fwd_we    = 1'b1;
        fwd_waddr = p_nxt;
        fwd_wdat  = x_nxt;
        inv_we    = 1'b1;
        inv_waddr = x_nxt;
        inv_wdat  = p_nxt;
        if (cnt_q == 8'd254) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ZERO: begin
        // Zero has no inverse, so the walk never reaches it; patch its entries here.
        fwd_we    = 1'b1;
        fwd_waddr = 8'h00;
        fwd_wdat  = AFFINE_C;
        inv_we    = 1'b1;
        inv_waddr = AFFINE_C;
        inv_wdat  = 8'h00;
        done_d    = 1'b1;
        state_d   = READY;
      end
      READY: begin
        data_d = sbox.decrypt_i ? inv_mem[sbox.data_i] : fwd_mem[sbox.data_i];
      end
      default: begin
        state_d = GEN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GEN;
      p_q     <= 8'h01;
      q_q     <= 8'h01;
      cnt_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fwd_we) begin
      fwd_mem[fwd_waddr] <= fwd_wdat;
    end
    if (!reset && inv_we) begin
      inv_mem[inv_waddr] <= inv_wdat;
    end
  end

  assign sbox.data_o      = data_q;
  assign sbox.init_done_o = done_q;

endmodule

// File: tb/tb_sbox_gen_responder.sv
// Bench for sbox_gen_responder: scoreboarded lookups against a GF(2^8) inverse + affine reference model.
module tb_sbox_gen_responder;

  logic clk = 1'b0;
  logic reset;

  sbox_gen_responder_if sif ();

  sbox_gen_responder #(.AFFINE_C(8'h63)) dut (
    .clk   (clk),
    .reset (reset),
    .sbox  (sif)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic       req_vld  = 1'b0;
  logic [7:0] m_fwd [256];
  logic [7:0] m_inv [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, aa, bb;
    r  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return r;
  endfunction

  // Reference: multiplicative inverse by exhaustive search, then the bitwise affine map.
  task automatic build_model();
    logic [7:0] c, b, s;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      b = 8'h00;
      for (int k = 1; k < 256; k++) begin
        if (a != 0 && gmul(8'(a), 8'(k)) == 8'h01) b = 8'(k);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      end
      m_fwd[a] = s;
      m_inv[s] = 8'(a);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every request sampled at an edge is answered right after that edge.
  initial begin
    logic       v;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      v = req_vld;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow got=%02h expected=<none>", sif.data_o);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", sif.data_o, e);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic dec, input logic [7:0] e);
    sif.data_i    = d;
    sif.decrypt_i = dec;
    req_vld       = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Runs n edges of generation with random dropped requests; init_done expected from edge done_at.
  task automatic gen_phase(input int n, input int done_at);
    for (int k = 1; k <= n; k++) begin
      sif.data_i    = 8'($urandom);
      sif.decrypt_i = 1'($urandom);
      req_vld       = 1'b1;
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1;
      check("init_done", 8'(sif.init_done_o), (k >= done_at) ? 8'h01 : 8'h00);
      @(negedge clk);
    end
  endtask

  task automatic reset_cycle();
    reset         = 1'b1;
    sif.data_i    = 8'($urandom);
    sif.decrypt_i = 1'($urandom);
    req_vld       = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge clk);
    #1;
    check("init_done_in_reset", 8'(sif.init_done_o), 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       dec;
    build_model();
    reset         = 1'b1;
    sif.data_i    = 8'h00;
    sif.decrypt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data_o", sif.data_o, 8'h00);
    check("reset_init_done", 8'(sif.init_done_o), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    gen_phase(256, 256);

    drive(8'h00, 1'b0, 8'h63);
    drive(8'h01, 1'b0, 8'h7C);
    drive(8'h53, 1'b0, 8'hED);
    drive(8'hFF, 1'b0, 8'h16);
    drive(8'h63, 1'b1, 8'h00);
    drive(8'h7C, 1'b1, 8'h01);
    drive(8'hED, 1'b1, 8'h53);
    drive(8'h16, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      dec = 1'(i % 2);
      drive(8'h53, dec, dec ? 8'h50 : 8'hED);
    end
    req_vld = 1'b0;
    @(negedge clk);

    // Reset after READY, then again part-way through generation.
    reset_cycle();
    gen_phase(99, 1000);
    reset_cycle();
    gen_phase(256, 256);
    drive(8'h53, 1'b0, 8'hED);

    for (int i = 0; i < 256; i++) drive(8'(i), 1'b0, m_fwd[i]);
    for (int i = 0; i < 256; i++) drive(m_fwd[i], 1'b1, 8'(i));
    repeat (300) begin
      d   = 8'($urandom);
      dec = 1'($urandom);
      drive(d, dec, dec ? m_inv[d] : m_fwd[d]);
    end
    req_vld = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drain", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
